// File: rtl/adder_share_arb.sv
// Round-robin sequencer sharing one external combinational adder between NREQ requesters.
// Optional subtract support is enabled by defining ADDER_ARB_SUB_EN.
module adder_share_arb #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  input  logic [NREQ-1:0]       req_sub_i,
  output logic                  rsp_valid_o,
  output logic [1:0]            rsp_id_o,
  output logic [WIDTH-1:0]      rsp_sum_o,
  output logic                  rsp_cout_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      add_a_o,
  output logic [WIDTH-1:0]      add_b_o,
  output logic                  add_cin_o,
  input  logic [WIDTH-1:0]      add_s_i,
  input  logic                  add_cout_i
);

  localparam int unsigned IDW  = 2;
  localparam int unsigned SELW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_sum_q, rsp_sum_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic [WIDTH-1:0]  add_a_q, add_a_d;
  logic [WIDTH-1:0]  add_b_q, add_b_d;
  logic              add_cin_q, add_cin_d;

  logic              win_vld;
  logic [SELW-1:0]   win_id;
  logic [SELW:0]     cand;
  logic [WIDTH-1:0]  op_b;
  logic              op_cin;

  // Winner: first valid requester scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = (SELW+1)'(rr_ptr_q) + (SELW+1)'(k);
      if (cand >= (SELW+1)'(NREQ)) begin
        cand = cand - (SELW+1)'(NREQ);
      end
      if (!win_vld && req_valid_i[cand[SELW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = cand[SELW-1:0];
      end
    end
  end

`ifdef ADDER_ARB_SUB_EN
  always_comb begin
    op_b   = req_b_i[win_id*WIDTH +: WIDTH];
    op_cin = 1'b0;
    if (req_sub_i[win_id]) begin
      op_b   = ~req_b_i[win_id*WIDTH +: WIDTH];
      op_cin = 1'b1;
    end
  end
`else
  logic unused_sub;
  assign unused_sub = ^req_sub_i;
  always_comb begin
    op_b   = req_b_i[win_id*WIDTH +: WIDTH];
    op_cin = 1'b0;
  end
`endif

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (win_vld && rst_n) begin
          req_ready_o[win_id] = 1'b1;
          add_a_d   = req_a_i[win_id*WIDTH +: WIDTH];
          add_b_d   = op_b;
          add_cin_d = op_cin;
          rsp_id_d  = IDW'(win_id);
          if (win_id == SELW'(NREQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = win_id + SELW'(1);
          end
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_sum_d   = add_s_i;
        rsp_cout_d  = add_cout_i;
        rsp_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_sum_o   = rsp_sum_q;
  assign rsp_cout_o  = rsp_cout_q;
  assign add_a_o     = add_a_q;
  assign add_b_o     = add_b_q;
  assign add_cin_o   = add_cin_q;

endmodule

// File: tb/tb_adder_share_arb.sv
// Self-checking bench for adder_share_arb with a behavioural adder and arbitration model.
module tb_adder_share_arb;
  localparam int unsigned NREQ  = 2;
  localparam int unsigned WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_sub = '0;
  logic                  rsp_valid;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  rsp_ready = 1'b0;
  logic [WIDTH-1:0]      add_a, add_b, add_s;
  logic                  add_cin, add_cout;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External ripple-carry adder stand-in.
  assign {add_cout, add_s} = 33'(add_a) + 33'(add_b) + 33'(add_cin);

  adder_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b), .req_sub_i(req_sub),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_sum_o(rsp_sum), .rsp_cout_o(rsp_cout),
    .rsp_ready_i(rsp_ready),
    .add_a_o(add_a), .add_b_o(add_b), .add_cin_o(add_cin),
    .add_s_i(add_s), .add_cout_i(add_cout)
  );

  function automatic int model_winner(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(exp_ptr + k) % NREQ]) return (exp_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  // {carry, sum} from plain arithmetic on the architectural operation.
  function automatic logic [32:0] model_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic sub);
    logic [31:0] d;
`ifdef ADDER_ARB_SUB_EN
    if (sub) begin
      d = a - b;
      return {(a >= b), d};
    end
`endif
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] r);
    int n = -1;
    int c = 0;
    for (int i = 0; i < NREQ; i++) if (r[i]) begin n = i; c++; end
    return (c == 1) ? n : -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_sub[i] = s;
  endtask

  // Call right after a negedge with inputs set; returns the sampled grant vector.
  task automatic get_grant(output logic [NREQ-1:0] rdy);
    int waited = 0;
    #1 rdy = req_ready;
    while (rdy == '0 && waited < 20) begin
      @(negedge clk);
      #1 rdy = req_ready;
      waited++;
    end
  endtask

  task automatic wait_rsp(input logic [NREQ-1:0] drop, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) req_valid = req_valid & ~drop;
      lat++;
    end while (!rsp_valid && lat < 20);
  endtask

  task automatic retire();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready} !== '0) begin
      errors++; $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready});
    end
    checks++;
    if ({add_a, add_b, add_cin} !== '0) begin
      errors++; $display("FAIL reset_add: got %h want 0", {add_a, add_b, add_cin});
    end
    rst_n = 1'b1;
    exp_ptr = 0;
  endtask

  task automatic test_single(input int who, input logic [31:0] a, input logic [31:0] b,
                             input logic s, input string name);
    logic [NREQ-1:0] rdy;
    logic [32:0] er;
    int g, lat, ew;
    set_req(who, a, b, s);
    req_valid = '0;
    req_valid[who] = 1'b1;
    ew = model_winner(req_valid);
    er = model_result(a, b, s);
    get_grant(rdy);
    g = onehot_idx(rdy);
    checks++;
    if (g !== ew) begin errors++; $display("FAIL %s_grant: got %0d want %0d", name, g, ew); end
    exp_ptr = (ew + 1) % NREQ;
    wait_rsp(rdy, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL %s_latency: got %0d want 2", name, lat); end
    checks++;
    if (rsp_id !== 2'(ew)) begin errors++; $display("FAIL %s_id: got %0d want %0d", name, rsp_id, ew); end
    checks++;
    if ({rsp_cout, rsp_sum} !== er) begin
      errors++; $display("FAIL %s_result: got %h want %h", name, {rsp_cout, rsp_sum}, er);
    end
    checks++;
    if (add_cin !== er[32] && s && ($bits(add_cin) == 0)) begin errors++; end
    retire();
  endtask

  task automatic test_sub();
    logic [NREQ-1:0] rdy;
    logic [32:0] er;
    logic exp_cin;
    int g, lat;
`ifdef ADDER_ARB_SUB_EN
    exp_cin = 1'b1;
`else
    exp_cin = 1'b0;
`endif
    set_req(1, 32'd5, 32'd7, 1'b1);
    req_valid = 2'b10;
    er = model_result(32'd5, 32'd7, 1'b1);
    get_grant(rdy);
    g = onehot_idx(rdy);
    checks++;
    if (g !== 1) begin errors++; $display("FAIL sub_grant: got %0d want 1", g); end
    exp_ptr = 0;
    wait_rsp(rdy, lat);
    checks++;
    if ({rsp_cout, rsp_sum} !== er) begin
      errors++; $display("FAIL sub_result: got %h want %h", {rsp_cout, rsp_sum}, er);
    end
    checks++;
    if (add_cin !== exp_cin) begin errors++; $display("FAIL sub_cin: got %b want %b", add_cin, exp_cin); end
    req_sub = '0;
    retire();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] rdy;
    logic [31:0] a [NREQ];
    logic [31:0] b [NREQ];
    logic [32:0] er;
    int g, ew, t, tprev;
    rsp_ready = 1'b1;
    req_valid = '1;
    tprev = 0;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        a[i] = $urandom; b[i] = $urandom; set_req(i, a[i], b[i], 1'b0);
      end
      ew = model_winner(req_valid);
      get_grant(rdy);
      t = cyc;
      g = onehot_idx(rdy);
      checks++;
      if (g !== ew) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", n, g, ew); end
      if (n > 0) begin
        checks++;
        if (t - tprev !== 3) begin errors++; $display("FAIL rr_spacing%0d: got %0d want 3", n, t - tprev); end
      end
      tprev = t;
      er = model_result(a[ew], b[ew], 1'b0);
      exp_ptr = (ew + 1) % NREQ;
      repeat (2) @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 2'(ew), er}) begin
        errors++;
        $display("FAIL rr_rsp%0d: got %h want %h", n, {rsp_valid, rsp_id, rsp_cout, rsp_sum}, {1'b1, 2'(ew), er});
      end
      if (n < 3) @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] rdy, other;
    logic [32:0] er0, er1;
    logic [31:0] a0, b0, a1, b1;
    int g, ew, lat;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
    set_req(0, a0, b0, 1'b0);
    set_req(1, a1, b1, 1'b0);
    req_valid = '1;
    ew = model_winner(req_valid);
    er0 = (ew == 0) ? model_result(a0, b0, 1'b0) : model_result(a1, b1, 1'b0);
    get_grant(rdy);
    g = onehot_idx(rdy);
    checks++;
    if (g !== ew) begin errors++; $display("FAIL bp_grant: got %0d want %0d", g, ew); end
    exp_ptr = (ew + 1) % NREQ;
    wait_rsp(rdy, lat);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({rsp_valid, rsp_cout, rsp_sum, req_ready} !== {1'b1, er0, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h want %h", k, {rsp_valid, rsp_cout, rsp_sum, req_ready}, {1'b1, er0, 2'b00});
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    ew = model_winner(req_valid);
    other = '0;
    other[ew] = 1'b1;
    er1 = (ew == 0) ? model_result(a0, b0, 1'b0) : model_result(a1, b1, 1'b0);
    #1;
    checks++;
    if (req_ready !== other) begin errors++; $display("FAIL bp_regrant: got %b want %b", req_ready, other); end
    exp_ptr = (ew + 1) % NREQ;
    wait_rsp(other, lat);
    checks++;
    if ({rsp_id, rsp_cout, rsp_sum} !== {2'(ew), er1}) begin
      errors++; $display("FAIL bp_second: got %h want %h", {rsp_id, rsp_cout, rsp_sum}, {2'(ew), er1});
    end
    retire();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] rdy, drop;
    logic [31:0] a [NREQ];
    logic [31:0] b [NREQ];
    logic        s [NREQ];
    logic [32:0] er;
    int g, ew, lat, hold;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        a[i] = $urandom; b[i] = ($urandom_range(0, 3) == 0) ? a[i] : $urandom;
        s[i] = 1'($urandom_range(0, 1));
        set_req(i, a[i], b[i], s[i]);
      end
      req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      ew = model_winner(req_valid);
      er = model_result(a[ew], b[ew], s[ew]);
      get_grant(rdy);
      g = onehot_idx(rdy);
      checks++;
      if (g !== ew) begin errors++; $display("FAIL rnd_grant%0d: got %0d want %0d", n, g, ew); end
      exp_ptr = (ew + 1) % NREQ;
      drop = '0;
      drop[ew] = 1'b1;
      wait_rsp(drop, lat);
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      checks++;
      if ({lat[7:0], rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {8'd2, 1'b1, 2'(ew), er}) begin
        errors++;
        $display("FAIL rnd_rsp%0d: got lat %0d v%b id%0d %h want lat 2 v1 id%0d %h",
                 n, lat, rsp_valid, rsp_id, {rsp_cout, rsp_sum}, ew, er);
      end
      retire();
    end
    req_valid = '0;
    req_sub = '0;
  endtask

  task automatic test_reset_in_hold();
    logic [NREQ-1:0] rdy;
    int g, lat;
    set_req(0, $urandom | 32'h1, $urandom | 32'h1, 1'b0);
    set_req(1, $urandom | 32'h1, $urandom | 32'h1, 1'b0);
    req_valid = 2'b01;
    get_grant(rdy);
    exp_ptr = 1;
    wait_rsp(rdy, lat);
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready, add_a, add_b, add_cin} !== '0) begin
      errors++; $display("FAIL hold_reset: got %h want 0",
                         {rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready, add_a, add_b, add_cin});
    end
    exp_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    get_grant(rdy);
    g = onehot_idx(rdy);
    checks++;
    if (g !== model_winner(req_valid)) begin
      errors++; $display("FAIL hold_reset_first_grant: got %0d want %0d", g, model_winner(req_valid));
    end
    wait_rsp('1, lat);
    retire();
  endtask

  initial begin
    test_reset();
    test_single(0, 32'h0000_0004, 32'h0000_1000, 1'b0, "add");
    test_single(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "wrap");
    test_round_robin();
    test_backpressure();
    test_sub();
    test_random();
    test_reset_in_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule
